// File: rtl/bus_rx_cross_domain.sv
// -----------------------------------------------------------------------------
// bus_rx_cross_domain
//
// Moves one WIDTH-bit word at a time from the source domain (clkB) to the sink
// domain (clkA) with a toggle request/acknowledge handshake. The source
// captures the word into a holding register and flips a request toggle. The
// sink synchronises that toggle and loads the word into BusOut. When the
// consumer takes the word, the sink flips an acknowledge toggle. The source
// synchronises the acknowledge toggle, and that frees the holding register for
// the next word. Only one word is ever in flight, so the sink needs no second
// buffer.
//
// Ports
//   clkA, rstA      sink clock and async active-high reset
//   clkB, rstB      source clock and async active-high reset
//   FlagIn_clkB     source request strobe, one clkB cycle per word
//   BusIn           source word, captured when the request is accepted
//   Busy_clkB       a transfer is in flight; a request is refused while high
//   DropCount_clkB  number of refused requests, saturating at 255
//   Valid_clkA      BusOut holds a word the consumer has not yet taken
//   Ready_clkA      the consumer takes the word
//   BusOut          received word, stable while Valid_clkA is high
// -----------------------------------------------------------------------------
module bus_rx_cross_domain #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clkA,
   input  logic             rstA,
   input  logic             clkB,
   input  logic             rstB,
   input  logic             FlagIn_clkB,
   input  logic [WIDTH-1:0] BusIn,
   output logic             Busy_clkB,
   output logic [7:0]       DropCount_clkB,
   output logic             Valid_clkA,
   input  logic             Ready_clkA,
   output logic [WIDTH-1:0] BusOut
);

   // ---------------------------------------------------------------------------
   // Source domain (clkB)
   // ---------------------------------------------------------------------------
   logic             req_toggle_q, req_toggle_d;
   logic [1:0]       ack_sync_q, ack_sync_d;
   logic [WIDTH-1:0] hold_q, hold_d;
   logic [7:0]       drop_cnt_q, drop_cnt_d;
   logic             busy;
   logic             accept;

   // The acknowledge toggle belongs to the sink domain. It is declared here so
   // that the source synchroniser can reference it.
   logic             ack_toggle_q, ack_toggle_d;

   always_comb begin
      busy         = req_toggle_q ^ ack_sync_q[1];
      accept       = FlagIn_clkB & ~busy;
      req_toggle_d = req_toggle_q ^ accept;
      // The holding register changes only when a request is accepted. It
      // therefore stays stable while the sink is sampling it.
      hold_d       = accept ? BusIn : hold_q;
      ack_sync_d   = {ack_sync_q[0], ack_toggle_q};
      drop_cnt_d   = drop_cnt_q;
      if (FlagIn_clkB && busy && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clkB or posedge rstB) begin
      if (rstB) begin
         req_toggle_q <= 1'b0;
         ack_sync_q   <= 2'b00;
         hold_q       <= '0;
         drop_cnt_q   <= 8'd0;
      end else begin
         req_toggle_q <= req_toggle_d;
         ack_sync_q   <= ack_sync_d;
         hold_q       <= hold_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign Busy_clkB      = busy;
   assign DropCount_clkB = drop_cnt_q;

   // ---------------------------------------------------------------------------
   // Sink domain (clkA)
   // ---------------------------------------------------------------------------
   typedef enum logic [0:0] {StIdle, StValid} state_e;

   state_e           state_q, state_d;
   logic [2:0]       req_sync_q, req_sync_d;
   logic [WIDTH-1:0] bus_out_q, bus_out_d;
   logic             new_req;

   // Stage 0 may go metastable. Stages 1 and 2 are settled, so comparing them
   // gives a one-cycle pulse for each toggle of the request.
   always_comb begin
      req_sync_d = {req_sync_q[1:0], req_toggle_q};
      new_req    = req_sync_q[2] ^ req_sync_q[1];
   end

   always_comb begin
      state_d      = state_q;
      bus_out_d    = bus_out_q;
      ack_toggle_d = ack_toggle_q;
      unique case (state_q)
         StIdle: begin
            // The source keeps hold_q unchanged until the acknowledge arrives.
            // Reading it across the domain boundary is therefore safe.
            if (new_req) begin
               state_d   = StValid;
               bus_out_d = hold_q;
            end
         end
         StValid: begin
            if (Ready_clkA) begin
               state_d      = StIdle;
               ack_toggle_d = ~ack_toggle_q;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clkA or posedge rstA) begin
      if (rstA) begin
         state_q      <= StIdle;
         req_sync_q   <= 3'b000;
         bus_out_q    <= '0;
         ack_toggle_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         req_sync_q   <= req_sync_d;
         bus_out_q    <= bus_out_d;
         ack_toggle_q <= ack_toggle_d;
      end
   end

   assign Valid_clkA = (state_q == StValid);
   assign BusOut     = bus_out_q;

endmodule

// File: tb/tb_bus_rx_cross_domain.sv
// -----------------------------------------------------------------------------
// tb_bus_rx_cross_domain
//
// Self-checking bench for bus_rx_cross_domain. A transaction-level model keeps
// a queue of accepted words and a saturating drop counter. It also keeps flags
// that say whether a word is in flight. The compare processes run on the
// falling edge of each clock, away from the active edge. Directed scenarios are
// mixed with randomised traffic.
// -----------------------------------------------------------------------------
`timescale 1ns/10ps
module tb_bus_rx_cross_domain;
   localparam int W = 8;

   logic         clkA = 1'b0;
   logic         clkB = 1'b0;
   logic         rstA = 1'b1;
   logic         rstB = 1'b1;
   logic         FlagIn_clkB = 1'b0;
   logic [W-1:0] BusIn = '0;
   logic         Ready_clkA = 1'b0;
   logic         Busy_clkB;
   logic [7:0]   DropCount_clkB;
   logic         Valid_clkA;
   logic [W-1:0] BusOut;

   realtime hb_a = 10.0;  // clkA 50 MHz
   realtime hb_b = 15.0;  // clkB ~33 MHz; the back-to-back tests change it

   always #(hb_a) clkA = ~clkA;
   always #(hb_b) clkB = ~clkB;

   bus_rx_cross_domain #(.WIDTH(W)) dut (
      .clkA           (clkA),
      .rstA           (rstA),
      .clkB           (clkB),
      .rstB           (rstB),
      .FlagIn_clkB    (FlagIn_clkB),
      .BusIn          (BusIn),
      .Busy_clkB      (Busy_clkB),
      .DropCount_clkB (DropCount_clkB),
      .Valid_clkA     (Valid_clkA),
      .Ready_clkA     (Ready_clkA),
      .BusOut         (BusOut)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   // ---------------------------------------------------------------------------
   // Transaction-level model
   // ---------------------------------------------------------------------------
   bit           chk_en = 1'b0;
   logic [W-1:0] exp_q[$];   // accepted words not yet consumed, in order
   logic [W-1:0] got_q[$];   // words the consumer took
   int           model_drop;
   bit           acc_pending, ack_pending, in_flight, expect_low;
   int           since_ack_b, wait_a;

   task automatic model_clear();
      exp_q.delete();
      model_drop  = 0;
      acc_pending = 1'b0;
      ack_pending = 1'b0;
      in_flight   = 1'b0;
      expect_low  = 1'b0;
      since_ack_b = 100;
      wait_a      = 0;
   endtask

   // An accept decided at a falling edge takes effect on the next rising edge.
   always @(posedge clkB) begin
      if (chk_en && acc_pending) begin
         acc_pending = 1'b0;
         in_flight   = 1'b1;
         wait_a      = 0;
      end
   end

   always @(posedge clkA) begin
      if (chk_en && ack_pending) begin
         ack_pending = 1'b0;
         in_flight   = 1'b0;
         since_ack_b = 0;
      end
   end

   // Source side: drop counter, busy window, accept/drop decision.
   always @(negedge clkB) begin
      if (chk_en) begin
         chk("drop_count", 32'(DropCount_clkB), 32'(model_drop));
         if (in_flight) chk("busy_in_flight", 32'(Busy_clkB), 1);
         // Busy must fall within three clkB edges once the ack has been sent.
         else if (since_ack_b >= 4) chk("busy_idle", 32'(Busy_clkB), 0);
         if (since_ack_b < 100) since_ack_b++;
         if (FlagIn_clkB) begin
            if (Busy_clkB) begin
               if (model_drop < 255) model_drop++;
            end else begin
               exp_q.push_back(BusIn);
               acc_pending = 1'b1;
            end
         end
      end
   end

   // Sink side: word content and order, one-cycle drop after ready, latency.
   always @(negedge clkA) begin
      if (chk_en) begin
         if (expect_low) begin
            chk("valid_falls", 32'(Valid_clkA), 0);
            expect_low = 1'b0;
         end else if (Valid_clkA) begin
            wait_a = 0;
            if (exp_q.size() == 0) begin
               chk("valid_unexpected", 32'(Valid_clkA), 0);
            end else begin
               chk("bus_out", 32'(BusOut), 32'(exp_q[0]));
               if (Ready_clkA) begin
                  got_q.push_back(exp_q.pop_front());
                  ack_pending = 1'b1;
                  expect_low  = 1'b1;
               end
            end
         end else if (in_flight) begin
            wait_a++;
            if (wait_a == 6) chk("valid_latency", 32'(Valid_clkA), 1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   task automatic send(input logic [W-1:0] d);
      int n;
      n = 0;
      @(posedge clkB); #0.1;
      while (Busy_clkB && n < 400) begin
         @(posedge clkB); #0.1;
         n++;
      end
      if (Busy_clkB) chk("send_busy_timeout", 32'(Busy_clkB), 0);
      FlagIn_clkB = 1'b1;
      BusIn       = d;
      @(posedge clkB); #0.1;
      FlagIn_clkB = 1'b0;
      BusIn       = W'($urandom);
   endtask

   task automatic wait_valid();
      int n;
      n = 0;
      while (!Valid_clkA && n < 60) begin
         @(negedge clkA);
         n++;
      end
      chk("wait_valid", 32'(Valid_clkA), 1);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || in_flight || acc_pending || Busy_clkB) && n < 2000) begin
         @(negedge clkA);
         n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 0);
      chk("drain_busy", 32'(Busy_clkB), 0);
   endtask

   task automatic apply_reset(input string tag);
      chk_en      = 1'b0;
      FlagIn_clkB = 1'b0;
      Ready_clkA  = 1'b0;
      rstA        = 1'b1;
      rstB        = 1'b1;
      repeat (3) @(negedge clkA);
      chk({tag, "_valid"}, 32'(Valid_clkA), 0);
      chk({tag, "_busy"}, 32'(Busy_clkB), 0);
      chk({tag, "_drop"}, 32'(DropCount_clkB), 0);
      chk({tag, "_busout"}, 32'(BusOut), 0);
      rstA = 1'b0;
      rstB = 1'b0;
      model_clear();
      repeat (2) @(negedge clkA);
      chk_en = 1'b1;
   endtask

   task automatic check_sequence(input string tag);
      chk({tag, "_count"}, 32'(got_q.size()), 256);
      for (int i = 0; i < 256 && i < got_q.size(); i++) begin
         chk({tag, "_word"}, 32'(got_q[i]), 32'(i));
      end
   endtask

   // ---------------------------------------------------------------------------
   // Main sequence
   // ---------------------------------------------------------------------------
   bit src_done;

   initial begin
      model_clear();
      apply_reset("rst");

      // Single transfer.
      got_q.delete();
      Ready_clkA = 1'b1;
      send(8'hA5);
      drain();
      chk("single_count", 32'(got_q.size()), 1);
      if (got_q.size() > 0) chk("single_word", 32'(got_q[0]), 32'h0000_00A5);

      // Backpressure.
      got_q.delete();
      @(posedge clkA); #0.1;
      Ready_clkA = 1'b0;
      send(8'h3C);
      wait_valid();
      repeat (20) begin
         @(negedge clkA);
         chk("bp_valid_held", 32'(Valid_clkA), 1);
         chk("bp_bus_held", 32'(BusOut), 32'h0000_003C);
      end
      chk("bp_busy_held", 32'(Busy_clkB), 1);
      @(posedge clkA); #0.1;
      Ready_clkA = 1'b1;
      @(negedge clkA);
      @(negedge clkA);
      chk("bp_valid_fell", 32'(Valid_clkA), 0);
      drain();
      chk("bp_count", 32'(got_q.size()), 1);

      // Randomised traffic with random backpressure.
      got_q.delete();
      src_done = 1'b0;
      fork
         begin
            repeat (600) begin
               @(posedge clkB); #0.1;
               FlagIn_clkB = ($urandom_range(0, 3) == 0);
               BusIn       = W'($urandom);
            end
            @(posedge clkB); #0.1;
            FlagIn_clkB = 1'b0;
            src_done    = 1'b1;
         end
         begin
            while (!src_done) begin
               @(posedge clkA); #0.1;
               Ready_clkA = ($urandom_range(0, 1) == 1);
            end
         end
      join
      @(posedge clkA); #0.1;
      Ready_clkA = 1'b1;
      drain();

      // Hold the request high; refusals must saturate the counter at 255.
      got_q.delete();
      @(posedge clkB); #0.1;
      FlagIn_clkB = 1'b1;
      repeat (400) begin
         BusIn = W'($urandom);
         @(posedge clkB); #0.1;
      end
      FlagIn_clkB = 1'b0;
      drain();
      chk("drop_saturated", 32'(DropCount_clkB), 255);
      // The round trip is about five clkB cycles, so 400 cycles deliver well
      // over 40 words.
      chk("drop_delivered", 32'(got_q.size() >= 40), 1);

      // Back-to-back with clkB four times faster than clkA.
      hb_b = 2.5;
      repeat (8) @(negedge clkA);
      got_q.delete();
      for (int i = 0; i < 256; i++) send(W'(i));
      drain();
      check_sequence("b2b_fast");

      // Back-to-back with clkB four times slower than clkA.
      hb_b = 40.0;
      repeat (8) @(negedge clkA);
      got_q.delete();
      for (int i = 0; i < 256; i++) send(W'(i));
      drain();
      check_sequence("b2b_slow");

      // Reset while a word is waiting in the sink, then a normal transfer.
      hb_b = 15.0;
      repeat (8) @(negedge clkA);
      @(posedge clkA); #0.1;
      Ready_clkA = 1'b0;
      send(8'h77);
      wait_valid();
      #3;
      apply_reset("midrst");
      got_q.delete();
      Ready_clkA = 1'b1;
      send(8'h5A);
      drain();
      chk("midrst_count", 32'(got_q.size()), 1);
      if (got_q.size() > 0) chk("midrst_word", 32'(got_q[0]), 32'h0000_005A);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d passed", n_pass,
               n_checks);
      $fatal(1, "watchdog");
   end

endmodule
